// File: rtl/gpu_pkg.sv
// Shared GPU core types: scheduler and fetcher state encodings plus program
// memory geometry constants.
package gpu_pkg;

  localparam int PROG_ADDR_BITS = 8;
  localparam int PROG_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational lookup, single-line fill,
// whole-cache flush. Only the valid bits are reset; tag/data are don't-care while invalid.
module icache_dm #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] lookup_addr_i,
  output logic                 hit_o,
  output logic [DATA_BITS-1:0] hit_data_o,
  input  logic                 fill_i,
  input  logic [ADDR_BITS-1:0] fill_addr_i,
  input  logic [DATA_BITS-1:0] fill_data_i,
  input  logic                 flush_i
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [DEPTH];
  logic [DATA_BITS-1:0] data_q [DEPTH];

  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] fl_idx;

  assign lk_idx     = lookup_addr_i[IDX_BITS-1:0];
  assign fl_idx     = fill_addr_i[IDX_BITS-1:0];
  assign hit_o      = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_addr_i[ADDR_BITS-1:IDX_BITS]);
  assign hit_data_o = data_q[lk_idx];

  // Flush outranks a coincident fill so the freshly written line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[fl_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[fl_idx]  <= fill_addr_i[ADDR_BITS-1:IDX_BITS];
      data_q[fl_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Per-core instruction fetch stage with valid/ready program-memory handshake.
// Optional direct-mapped I-cache enabled by defining FETCH_ICACHE_EN.
module instr_fetcher
  import gpu_pkg::*;
#(
  parameter int PROG_ADDR_BITS = 8,
  parameter int PROG_DATA_BITS = 16,
  parameter int ICACHE_DEPTH   = 8,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                core_state,
  input  logic [PROG_ADDR_BITS-1:0] current_pc,
  input  logic                      flush,
  output logic                      mem_read_valid,
  output logic [PROG_ADDR_BITS-1:0] mem_read_address,
  input  logic                      mem_read_ready,
  input  logic [PROG_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                fetcher_state,
  output logic [PROG_DATA_BITS-1:0] instruction,
  output logic [STALL_CNT_BITS-1:0] stall_cycles
);

  fetcher_state_t              state_q, state_d;
  logic                        valid_q, valid_d;
  logic [PROG_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [PROG_DATA_BITS-1:0]   instr_q, instr_d;
  logic [STALL_CNT_BITS-1:0]   stall_q, stall_d;
  logic                        fill_en;
  logic                        cache_hit;
  logic [PROG_DATA_BITS-1:0]   cache_data;

`ifdef FETCH_ICACHE_EN
  icache_dm #(
    .ADDR_BITS (PROG_ADDR_BITS),
    .DATA_BITS (PROG_DATA_BITS),
    .DEPTH     (ICACHE_DEPTH)
  ) u_icache (
    .clk           (clk),
    .rst_n         (reset),
    .lookup_addr_i (current_pc),
    .hit_o         (cache_hit),
    .hit_data_o    (cache_data),
    .fill_i        (fill_en),
    .fill_addr_i   (addr_q),
    .fill_data_i   (mem_read_data),
    .flush_i       (flush)
  );
`else
  localparam int ICACHE_DEPTH_UNUSED = ICACHE_DEPTH;
  logic cache_ctrl_unused;

  assign cache_hit         = 1'b0;
  assign cache_data        = '0;
  assign cache_ctrl_unused = flush | fill_en;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    stall_d = stall_q;
    fill_en = 1'b0;
    unique case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instr_d = cache_data;
            state_d = FETCHER_FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (stall_q != '1) stall_d = stall_q + STALL_CNT_BITS'(1);
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          fill_en = 1'b1;
          state_d = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCHER_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign stall_cycles     = stall_q;

  // The scheduler must hold FETCH until the outstanding request has returned.
  ap_fetch_held : assert property (@(posedge clk) disable iff (!reset)
    (state_q == FETCHER_FETCHING) |-> (core_state == CORE_FETCH));

endmodule
